// File: rtl/program_loader.sv
// program_loader: streams a program into instruction memory, optionally verifies
// a trailing checksum word, then releases the pipeline core from reset.
// Optional checksum stage: define LOADER_CHECKSUM_EN to enable it.
module program_loader #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CHECK   = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4,
        FAIL    = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] count;
    // Set for the cycle after the final program beat so that RELEASE starts
    // only once the last write strobe has been presented to memory.
    logic          drain;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   sum;
`endif

    logic accept_c;
    logic restart_c;

    // Beat handshake and load (re)start qualification.
    always_comb begin
        accept_c  = in_valid && in_ready;
        restart_c = start && ((state == IDLE) || (state == RUN) || (state == FAIL));
    end

    // Loader FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            drain      <= 1'b0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (restart_c) begin
                state    <= LOAD;
                count    <= '0;
                drain    <= 1'b0;
                in_ready <= 1'b1;
                core_rst <= 1'b0;
                done     <= 1'b0;
                error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                sum      <= '0;
`endif
            end else begin
                case (state)
                    LOAD: begin
                        if (drain) begin
                            drain <= 1'b0;
                            state <= RELEASE;
                        end else if (accept_c) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= 32'({count, 2'b00});
                            imem_wdata <= in_data;
                            count      <= count + AW'(1);
`ifdef LOADER_CHECKSUM_EN
                            sum        <= sum + in_data;
`endif
                            if ((count == LAST_IDX) && !in_last) begin
                                // Memory full but the source has more words.
                                error    <= 1'b1;
                                in_ready <= 1'b0;
                                state    <= FAIL;
                            end else if (in_last) begin
`ifdef LOADER_CHECKSUM_EN
                                state    <= CHECK;
`else
                                in_ready <= 1'b0;
                                drain    <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHECK: begin
                        if (accept_c) begin
                            in_ready <= 1'b0;
                            if (in_data == sum) begin
                                state <= RELEASE;
                            end else begin
                                error <= 1'b1;
                                state <= FAIL;
                            end
                        end
                    end
`endif
                    RELEASE: begin
                        state    <= RUN;
                        core_rst <= 1'b1;
                        done     <= 1'b1;
                    end
                    IDLE, RUN, FAIL: begin
                        state <= state;
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        core_rst <= 1'b0;
                        done     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a cycle table for the main load/run flow
// plus hand sequences for overflow, asynchronous reset and the checksum stage.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, in_last;
    logic [31:0] in_data;
    logic        in_ready, imem_we, core_rst, done, error;
    logic [31:0] imem_addr, imem_wdata;

    logic        s_start, s_valid, s_last;
    logic [31:0] s_data;
    logic        s_ready, s_we, s_crst, s_done, s_err;
    logic [31:0] s_addr, s_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_loader #(.DEPTH(64), .AW(6)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .done(done), .error(error)
    );

    program_loader #(.DEPTH(4), .AW(2)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid),
        .in_data(s_data), .in_last(s_last), .in_ready(s_ready),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .core_rst(s_crst), .done(s_done), .error(s_err)
    );

    typedef struct {
        logic        st;
        logic        vld;
        logic        lst;
        logic [31:0] dat;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        crst;
        logic        dn;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic vld, input logic lst,
                                input logic [31:0] dat, input logic rdy, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic crst, input logic dn, input logic err);
        vec_t v;
        v.st = st; v.vld = vld; v.lst = lst; v.dat = dat;
        v.rdy = rdy; v.we = we; v.addr = addr; v.wdata = wdata;
        v.crst = crst; v.dn = dn; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic vld, input logic lst, input logic [31:0] dat);
        start    = st;
        in_valid = vld;
        in_last  = lst;
        in_data  = dat;
    endtask

    task automatic load_beat(input logic lst, input logic [31:0] dat, input logic [31:0] addr,
                             input string name);
        drive(1'b0, 1'b1, lst, dat);
        step();
        chk({name, "_we"}, 32'(imem_we), 32'd1);
        chk({name, "_addr"}, imem_addr, addr);
        chk({name, "_wdata"}, imem_wdata, dat);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        s_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 32'h0;

        // Table: basic load, RUN restart with one-word reload, valid toggling.
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h00500093, 1, 1, 32'h0, 32'h00500093, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h00300113, 1, 1, 32'h4, 32'h00300113, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h002081B3, 0, 1, 32'h8, 32'h002081B3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,        1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 32'h11111111, 0, 0, 32'h0, 32'h0,        1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'hDEADBEEF, 0, 1, 32'h0, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,        1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'hAAAA0001, 1, 1, 32'h0, 32'hAAAA0001, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'hAAAA0002, 0, 1, 32'h4, 32'hAAAA0002, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,        1, 1, 0));

        // Reset state.
        step();
        step();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_crst", 32'(core_rst), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        rst = 1'b1;
        step();
        chk("idle_ready", 32'(in_ready), 32'd0);

`ifndef LOADER_CHECKSUM_EN
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].vld, tbl[i].lst, tbl[i].dat);
            step();
            chk($sformatf("t%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("t%0d_we", i), 32'(imem_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
                chk($sformatf("t%0d_wdata", i), imem_wdata, tbl[i].wdata);
            end
            chk($sformatf("t%0d_crst", i), 32'(core_rst), 32'(tbl[i].crst));
            chk($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("t%0d_err", i), 32'(error), 32'(tbl[i].err));
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
`endif

        // Overflow on the DEPTH=4 instance: four words, no in_last.
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("ovf_ready0", 32'(s_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h100 + 32'(i);
            step();
            chk($sformatf("ovf%0d_we", i), 32'(s_we), 32'd1);
            chk($sformatf("ovf%0d_addr", i), s_addr, 32'(4 * i));
            chk($sformatf("ovf%0d_wdata", i), s_wdata, 32'h100 + 32'(i));
            chk($sformatf("ovf%0d_crst", i), 32'(s_crst), 32'd0);
        end
        chk("ovf_err", 32'(s_err), 32'd1);
        chk("ovf_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("ovf_hold%0d_we", i), 32'(s_we), 32'd0);
            chk($sformatf("ovf_hold%0d_crst", i), 32'(s_crst), 32'd0);
            chk($sformatf("ovf_hold%0d_err", i), 32'(s_err), 32'd1);
            chk($sformatf("ovf_hold%0d_done", i), 32'(s_done), 32'd0);
        end
        s_valid = 1'b0;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("ovf_restart_err", 32'(s_err), 32'd0);
        chk("ovf_restart_ready", 32'(s_ready), 32'd1);

        // Asynchronous reset in the middle of a five-word load.
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        load_beat(1'b0, 32'h00000011, 32'h0, "mid_b0");
        load_beat(1'b0, 32'h00000022, 32'h4, "mid_b1");
        drive(1'b0, 1'b1, 1'b0, 32'h00000033);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_wdata", imem_wdata, 32'h0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_crst", 32'(core_rst), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(error), 32'd0);
        step();
        chk("arst_hold_we", 32'(imem_we), 32'd0);
        rst = 1'b1;
        step();
        chk("idle_valid_we", 32'(imem_we), 32'd0);
        chk("idle_valid_ready", 32'(in_ready), 32'd0);
        chk("idle_valid_crst", 32'(core_rst), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("reload_ready", 32'(in_ready), 32'd1);
        load_beat(1'b1, 32'h00000033, 32'h0, "reload");
`ifdef LOADER_CHECKSUM_EN
        drive(1'b0, 1'b1, 1'b0, 32'h00000033);
        step();
        chk("reload_sum_we", 32'(imem_we), 32'd0);
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        chk("reload_crst", 32'(core_rst), 32'd1);
        chk("reload_done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match then mismatch.
        for (int pass = 0; pass < 2; pass++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            step();
            chk($sformatf("cs%0d_start_crst", pass), 32'(core_rst), 32'd0);
            load_beat(1'b0, 32'd1, 32'h0, $sformatf("cs%0d_b0", pass));
            load_beat(1'b0, 32'd2, 32'h4, $sformatf("cs%0d_b1", pass));
            load_beat(1'b1, 32'd3, 32'h8, $sformatf("cs%0d_b2", pass));
            chk($sformatf("cs%0d_check_ready", pass), 32'(in_ready), 32'd1);
            drive(1'b0, 1'b1, 1'b0, (pass == 0) ? 32'd6 : 32'd7);
            step();
            chk($sformatf("cs%0d_sum_we", pass), 32'(imem_we), 32'd0);
            chk($sformatf("cs%0d_sum_ready", pass), 32'(in_ready), 32'd0);
            chk($sformatf("cs%0d_sum_err", pass), 32'(error), (pass == 0) ? 32'd0 : 32'd1);
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            step();
            step();
            chk($sformatf("cs%0d_crst", pass), 32'(core_rst), (pass == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cs%0d_done", pass), 32'(done), (pass == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cs%0d_err", pass), 32'(error), (pass == 0) ? 32'd0 : 32'd1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
